// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: armed ADC capture engine feeding the sample FIFO (ADC_CAPTURE_DECIMATE_EN adds decimation)
module adc_capture_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int LEN_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [LEN_W-1:0]         capture_len,
  input  logic [DATA_W-1:0]        threshold,
  input  logic                     link_ready,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic                     fifo_prog_full,
  output logic                     fifo_wr_en,
  output logic [NUM_CH*DATA_W-1:0] fifo_din,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              overflow_count
`ifdef ADC_CAPTURE_DECIMATE_EN
  ,
  input  logic [7:0]               decim
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [1:0] mode_q;
  logic [LEN_W-1:0] len_q, cnt;
  logic signed [DATA_W-1:0] thr_q, prev, ch0;
  logic prev_vld, acc, idle_ok, cont, trig, cap, dec_ok, cand, wr, drop, fin, zlen;
`ifdef ADC_CAPTURE_DECIMATE_EN
  logic [7:0] decim_q, dcnt, dbase;
  always_comb begin
    dbase = trig ? 8'd0 : dcnt;
    dec_ok = dbase == 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      decim_q <= '0;
      dcnt <= '0;
    end else if (idle_ok && arm) begin
      decim_q <= decim;
      dcnt <= '0;
    end else if (cap) begin
      dcnt <= dbase == decim_q ? 8'd0 : dbase + 8'd1;
    end
  end
`else
  assign dec_ok = 1'b1;
`endif
  always_comb begin
    ch0 = sample_data[NUM_CH*DATA_W-1 -: DATA_W];
    acc = sample_valid && link_ready;
    idle_ok = state == IDLE || state == DONE;
    cont = mode_q == 2'd0;
    trig = state == WAIT_TRIG && acc && prev_vld && prev < thr_q && ch0 >= thr_q;
    cap = (state == CAPTURE && acc) || trig;
    cand = cap && dec_ok && (cont || len_q != '0);
    wr = cand && !fifo_prog_full;
    drop = cand && fifo_prog_full;
    fin = wr && !cont && cnt + LEN_W'(1) == len_q;
    zlen = state == CAPTURE && !cont && len_q == '0;
    nxt = idle_ok ? (arm ? (mode == 2'd2 ? WAIT_TRIG : CAPTURE) : state)
        : (stop || fin || zlen) ? DONE
        : trig ? CAPTURE : state;
    busy = state == WAIT_TRIG || state == CAPTURE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr_en <= 1'b0;
      fifo_din <= '0;
      overflow_count <= '0;
      cnt <= '0;
      mode_q <= '0;
      len_q <= '0;
      thr_q <= '0;
      prev <= '0;
      prev_vld <= 1'b0;
    end else begin
      fifo_wr_en <= wr;
      if (wr) fifo_din <= sample_data;
      if (idle_ok && arm) begin
        mode_q <= mode;
        len_q <= capture_len;
        thr_q <= threshold;
        cnt <= '0;
        overflow_count <= '0;
        prev_vld <= 1'b0;
      end else begin
        if (wr) cnt <= cnt + LEN_W'(1);
        if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        if (state == WAIT_TRIG && acc) begin
          prev <= ch0;
          prev_vld <= 1'b1;
        end
      end
    end
  end
endmodule
